// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table, gain constant, quadrant and FSM encodings.
// Used by the vectoring engine and by the paired rotation CORDIC.
package cordic_pkg;

    localparam int LUT_STAGES      = 16;
    localparam int LUT_ANGLE_WIDTH = 16;

    // atan(2^-i) with +/-180 deg mapped to +/-2^(LUT_ANGLE_WIDTH-1), rounded to nearest LSB
    localparam logic signed [LUT_ANGLE_WIDTH-1:0] ATAN_LUT [0:LUT_STAGES-1] = '{
        16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
        16'sd651,  16'sd326,  16'sd163,  16'sd81,
        16'sd41,   16'sd20,   16'sd10,   16'sd5,
        16'sd3,    16'sd1,    16'sd1,    16'sd0
    };

    // K = 0.607253 as unsigned Q0.16
    localparam int                      CORDIC_GAIN_FRAC = 16;
    localparam logic [CORDIC_GAIN_FRAC:0] CORDIC_GAIN_K  = 17'd39797;

    typedef enum logic [1:0] {
        QUAD_POS    = 2'b00,
        QUAD_NEG_UP = 2'b01,
        QUAD_NEG_DN = 2'b10
    } quad_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_ITER = 2'b10,
        ST_POST = 2'b11
    } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup: micro-rotation index -> atan(2^-idx) in angle units.
// Shared between the vectoring engine and the rotation CORDIC.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16,
    parameter int IDX_W         = $clog2(CORDIC_STAGES)
) (
    input  logic [IDX_W-1:0]              idx,
    output logic signed [ANGLE_WIDTH-1:0] atan
);

    assign atan = ANGLE_WIDTH'(ATAN_LUT[idx]);

endmodule

// File: rtl/cordic_vec_engine.sv
// Iterative CORDIC vectoring engine: magnitude, entry quadrant, per-stage direction bits, optional angle.
// Define CORDIC_VEC_GAIN_COMP_EN to scale the magnitude by K so xout is the true Euclidean norm.
module cordic_vec_engine
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int CORDIC_WIDTH  = 22,
    parameter int ANGLE_WIDTH   = 16,
    parameter int CORDIC_STAGES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic signed [DATA_WIDTH-1:0]   xin,
    input  logic signed [DATA_WIDTH-1:0]   yin,
    input  logic                           angle_calc_en,
    output logic                           busy,
    output logic                           microRot_out_start,
    output logic [1:0]                     quad_out,
    output logic [CORDIC_STAGES-1:0]       microRot_out,
    output logic                           opvld,
    output logic signed [DATA_WIDTH-1:0]   xout,
    output logic signed [ANGLE_WIDTH-1:0]  angle_out
);

    localparam int GUARD   = 4;
    localparam int IDX_W   = $clog2(CORDIC_STAGES);
    localparam int MAG_MAX = 2**(DATA_WIDTH-1) - 1;

`ifdef CORDIC_VEC_GAIN_COMP_EN
    localparam int PROD_W    = CORDIC_WIDTH + CORDIC_GAIN_FRAC + 2;
    localparam int OUT_SHIFT = CORDIC_GAIN_FRAC + GUARD;
`else
    localparam int PROD_W    = CORDIC_WIDTH + 1;
    localparam int OUT_SHIFT = GUARD;
`endif

    localparam logic signed [ANGLE_WIDTH-1:0] Z_P90 = ANGLE_WIDTH'(2**(ANGLE_WIDTH-2));
    localparam logic signed [ANGLE_WIDTH-1:0] Z_M90 = -Z_P90;

    state_t                          state, state_nxt;
    logic [IDX_W-1:0]                iter_idx;
    logic signed [CORDIC_WIDTH-1:0]  x_r, y_r;
    logic signed [ANGLE_WIDTH-1:0]   z_r;
    logic                            angle_en_r;
    logic                            zero_r;

    logic signed [CORDIC_WIDTH-1:0]  x_sh, y_sh;
    logic signed [ANGLE_WIDTH-1:0]   atan_i;
    logic                            dir;
    quad_t                           quad_pre;

    // Optional gain compensation, round-half-up removal of guard bits, saturation to the output range
    function automatic logic signed [DATA_WIDTH-1:0] scale_out(input logic signed [CORDIC_WIDTH-1:0] x);
        logic signed [PROD_W-1:0] acc;
        logic signed [PROD_W-1:0] lim;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        acc = PROD_W'(x) * PROD_W'($signed({1'b0, CORDIC_GAIN_K}));
`else
        acc = PROD_W'(x);
`endif
        acc = acc + (PROD_W'(1) <<< (OUT_SHIFT - 1));
        acc = acc >>> OUT_SHIFT;
        lim = PROD_W'(MAG_MAX);
        if (acc > lim)
            return DATA_WIDTH'(MAG_MAX);
        else if (acc < 0)
            return '0;
        else
            return DATA_WIDTH'(acc);
    endfunction

    cordic_atan_rom #(
        .ANGLE_WIDTH   (ANGLE_WIDTH),
        .CORDIC_STAGES (CORDIC_STAGES)
    ) u_atan_rom (
        .idx  (iter_idx),
        .atan (atan_i)
    );

    assign busy = (state != ST_IDLE);
    assign x_sh = x_r >>> iter_idx;
    assign y_sh = y_r >>> iter_idx;
    assign dir  = ~y_r[CORDIC_WIDTH-1];

    always_comb begin
        quad_pre = QUAD_POS;
        if (x_r[CORDIC_WIDTH-1])
            quad_pre = y_r[CORDIC_WIDTH-1] ? QUAD_NEG_DN : QUAD_NEG_UP;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_PRE;
            ST_PRE:  state_nxt = ST_ITER;
            ST_ITER: if (iter_idx == IDX_W'(CORDIC_STAGES - 1)) state_nxt = ST_POST;
            ST_POST: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control and outputs: cleared by reset so an in-flight request never completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            iter_idx           <= '0;
            angle_en_r         <= 1'b0;
            zero_r             <= 1'b0;
            microRot_out_start <= 1'b0;
            quad_out           <= 2'b00;
            microRot_out       <= '0;
            opvld              <= 1'b0;
            xout               <= '0;
            angle_out          <= '0;
        end else begin
            state              <= state_nxt;
            microRot_out_start <= 1'b0;
            opvld              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        angle_en_r <= angle_calc_en;
                        zero_r     <= (xin == '0) && (yin == '0);
                    end
                end
                ST_PRE: begin
                    quad_out           <= quad_pre;
                    microRot_out_start <= 1'b1;
                    microRot_out       <= '0;
                    iter_idx           <= '0;
                end
                ST_ITER: begin
                    microRot_out[iter_idx] <= dir;
                    iter_idx               <= iter_idx + IDX_W'(1);
                end
                ST_POST: begin
                    xout      <= scale_out(x_r);
                    angle_out <= (zero_r || !angle_en_r) ? '0 : z_r;
                    opvld     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: x/y/z carry no reset, they are always reloaded on acceptance
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (en) begin
                    x_r <= CORDIC_WIDTH'(xin) <<< GUARD;
                    y_r <= CORDIC_WIDTH'(yin) <<< GUARD;
                    z_r <= '0;
                end
            end
            ST_PRE: begin
                case (quad_pre)
                    QUAD_NEG_UP: begin
                        x_r <= y_r;
                        y_r <= -x_r;
                        z_r <= angle_en_r ? Z_P90 : '0;
                    end
                    QUAD_NEG_DN: begin
                        x_r <= -y_r;
                        y_r <= x_r;
                        z_r <= angle_en_r ? Z_M90 : '0;
                    end
                    default: z_r <= '0;
                endcase
            end
            ST_ITER: begin
                if (dir) begin
                    x_r <= x_r + y_sh;
                    y_r <= y_r - x_sh;
                    if (angle_en_r) z_r <= z_r + atan_i;
                end else begin
                    x_r <= x_r - y_sh;
                    y_r <= y_r + x_sh;
                    if (angle_en_r) z_r <= z_r - atan_i;
                end
            end
            default: ;
        endcase
    end

endmodule
